// File: rtl/character_buffer_packer.sv
// character_buffer_packer
// Packs a stream of 8-bit ASCII codes from the keyboard decoder into 64-bit
// words (eight characters each) and rewrites the word in progress into the
// 32-entry character buffer after every accepted edit. Backspace removes the
// last character of the current word, the flush character closes the word
// early, and the block stops accepting input once all 32 words are committed.
module character_buffer_packer #(
  parameter logic [7:0] FLUSH_CHAR     = 8'h0D,
  parameter logic [7:0] BACKSPACE_CHAR = 8'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [63:0] data_out,
  output logic [4:0]  address,
  output logic        write,
  output logic        full
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  localparam logic [4:0] LAST_PTR = 5'd31;

  state_e      state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        wrap_q, wrap_d;
  logic        full_q, full_d;

  logic        accept;
  logic        is_printable;
  logic        is_backspace;
  logic        is_flush;
  logic [2:0]  idx_prev;
  logic [5:0]  put_base;
  logic [5:0]  del_base;

  // Decode the incoming character and the handshake once so both the FSM and
  // the datapath see the same view of what is being accepted this cycle.
  always_comb begin
    char_ready   = (state_q == IDLE) && !full_q;
    accept       = char_valid && char_ready;
    is_backspace = (char_in == BACKSPACE_CHAR);
    is_flush     = (char_in == FLUSH_CHAR);
    is_printable = (char_in >= PRINT_LO) && (char_in <= PRINT_HI)
                   && !is_backspace && !is_flush;
    idx_prev     = idx_q - 3'd1;
    put_base     = {idx_q, 3'b000};
    del_base     = {idx_prev, 3'b000};
  end

  // State register plus datapath flops; reset wins over any accepted input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= 64'h0;
      idx_q    <= 3'd0;
      ptr_q    <= 5'd0;
      wrap_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      wrap_q   <= wrap_d;
      full_q   <= full_d;
    end
  end

  // Next FSM state: only edits that change the live word need a WRITE cycle;
  // flushes, no-op edits and dropped codes stay in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_backspace) begin
            if (idx_q != 3'd0) begin
              state_d = WRITE;
            end
          end else if (is_printable) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath update: build the word in place, and advance the pointer either
  // when a flush closes a partial word or after the write of a completed word.
  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    wrap_d   = wrap_q;
    full_d   = full_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_backspace) begin
            if (idx_q != 3'd0) begin
              idx_d                  = idx_prev;
              shadow_d[del_base +: 8] = 8'h00;
            end
          end else if (is_flush) begin
            if (idx_q != 3'd0) begin
              shadow_d = 64'h0;
              idx_d    = 3'd0;
              if (ptr_q == LAST_PTR) begin
                full_d = 1'b1;
              end else begin
                ptr_d = ptr_q + 5'd1;
              end
            end
          end else if (is_printable) begin
            shadow_d[put_base +: 8] = char_in;
            wrap_d                  = (idx_q == 3'd7);
            idx_d                   = idx_q + 3'd1;
          end
        end
      end
      WRITE: begin
        if (wrap_q) begin
          shadow_d = 64'h0;
          if (ptr_q == LAST_PTR) begin
            full_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 5'd1;
          end
        end
        wrap_d = 1'b0;
      end
      default: begin
        wrap_d = 1'b0;
      end
    endcase
  end

  // Outputs: the write strobe is exactly the WRITE state; the word and
  // pointer are presented directly so the buffer sees the live text.
  always_comb begin
    write    = (state_q == WRITE);
    data_out = shadow_q;
    address  = ptr_q;
    full     = full_q;
  end

endmodule

// File: tb/tb_character_buffer_packer.sv
// Testbench for character_buffer_packer: table-driven edit sequences with a
// write scoreboard, plus hand-written fill-to-full and reset-in-WRITE cases.
module tb_character_buffer_packer;

  logic        clock;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [63:0] data_out;
  logic [4:0]  address;
  logic        write;
  logic        full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    bit          is_reset;
    logic [7:0]  ch;
    bit          exp_write;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    logic [4:0]  addr_after;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[$];

  character_buffer_packer dut (
    .clock      (clock),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .data_out   (data_out),
    .address    (address),
    .write      (write),
    .full       (full)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clock) begin
    if (write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", address, data_out);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (address !== e.addr || data_out !== e.data) begin
          errors++;
          $display("[TB] FAIL write_contents: got addr=%0d data=%h, required addr=%0d data=%h",
                   address, data_out, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) for char_ready, present one character for one edge and
  // queue the write it should cause, if any.
  task automatic applyStimulus(input logic [7:0] ch, input bit exp_write,
                               input logic [4:0] exp_addr, input logic [63:0] exp_data);
    int waited;
    waited = 0;
    @(negedge clock);
    while (char_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (char_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got char_ready=%b, required 1", char_ready);
      return;
    end
    if (exp_write) sb.push_back('{addr: exp_addr, data: exp_data});
    char_in    = ch;
    char_valid = 1'b1;
    @(posedge clock);
    #1 char_valid = 1'b0;
  endtask

  task automatic addVec(input bit r, input logic [7:0] ch, input bit w,
                        input logic [4:0] a, input logic [63:0] d, input logic [4:0] aa);
    vecs.push_back('{is_reset: r, ch: ch, exp_write: w, exp_addr: a, exp_data: d, addr_after: aa});
  endtask

  initial begin
    logic [63:0] word;
    logic [7:0]  c;

    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;

    // Reset values
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_write",      {63'h0, write},      64'h0);
    checkOutput("reset_full",       {63'h0, full},       64'h0);
    checkOutput("reset_address",    {59'h0, address},    64'h0);
    checkOutput("reset_data_out",   data_out,            64'h0);
    checkOutput("reset_char_ready", {63'h0, char_ready}, 64'h1);

    // Single character
    addVec(1, 8'h00, 0, 0, 64'h0, 0);
    addVec(0, 8'h41, 1, 0, 64'h41, 0);
    // Full word "ABCDEFGH" then "I" on the next word
    addVec(1, 8'h00, 0, 0, 64'h0, 0);
    addVec(0, 8'h41, 1, 0, 64'h0000_0000_0000_0041, 0);
    addVec(0, 8'h42, 1, 0, 64'h0000_0000_0000_4241, 0);
    addVec(0, 8'h43, 1, 0, 64'h0000_0000_0043_4241, 0);
    addVec(0, 8'h44, 1, 0, 64'h0000_0000_4443_4241, 0);
    addVec(0, 8'h45, 1, 0, 64'h0000_0045_4443_4241, 0);
    addVec(0, 8'h46, 1, 0, 64'h0000_4645_4443_4241, 0);
    addVec(0, 8'h47, 1, 0, 64'h0047_4645_4443_4241, 0);
    addVec(0, 8'h48, 1, 0, 64'h4847_4645_4443_4241, 1);
    addVec(0, 8'h49, 1, 1, 64'h0000_0000_0000_0049, 1);
    // Backspace, including one at idx==0
    addVec(1, 8'h00, 0, 0, 64'h0, 0);
    addVec(0, 8'h41, 1, 0, 64'h41, 0);
    addVec(0, 8'h42, 1, 0, 64'h4241, 0);
    addVec(0, 8'h08, 1, 0, 64'h41, 0);
    addVec(0, 8'h08, 1, 0, 64'h0, 0);
    addVec(0, 8'h08, 0, 0, 64'h0, 0);
    // Carriage return, CR at idx==0, dropped codes and printable boundaries
    addVec(1, 8'h00, 0, 0, 64'h0, 0);
    addVec(0, 8'h41, 1, 0, 64'h41, 0);
    addVec(0, 8'h42, 1, 0, 64'h4241, 0);
    addVec(0, 8'h0D, 0, 0, 64'h0, 1);
    addVec(0, 8'h43, 1, 1, 64'h43, 1);
    addVec(0, 8'h0D, 0, 0, 64'h0, 2);
    addVec(0, 8'h0D, 0, 0, 64'h0, 2);
    addVec(0, 8'h44, 1, 2, 64'h44, 2);
    addVec(0, 8'h01, 0, 0, 64'h0, 2);
    addVec(0, 8'h45, 1, 2, 64'h4544, 2);
    addVec(0, 8'h7F, 0, 0, 64'h0, 2);
    addVec(0, 8'h7E, 1, 2, 64'h7E_4544, 2);
    addVec(0, 8'h1F, 0, 0, 64'h0, 2);
    addVec(0, 8'h20, 1, 2, 64'h207E_4544, 2);

    foreach (vecs[i]) begin
      if (vecs[i].is_reset) begin
        doReset();
      end else begin
        applyStimulus(vecs[i].ch, vecs[i].exp_write, vecs[i].exp_addr, vecs[i].exp_data);
        @(negedge clock);
        checkOutput($sformatf("ready_after_accept[%0d]", i), {63'h0, char_ready},
                    {63'h0, !vecs[i].exp_write});
        @(negedge clock);
        checkOutput($sformatf("ready_settled[%0d]", i), {63'h0, char_ready}, 64'h1);
        checkOutput($sformatf("address_after[%0d]", i), {59'h0, address},
                    {59'h0, vecs[i].addr_after});
      end
    end

    // Fill all 32 words with printable characters
    doReset();
    word = 64'h0;
    for (int i = 0; i < 256; i++) begin
      c = 8'h20 + 8'(i % 95);
      if ((i % 8) == 0) word = 64'h0;
      word[(i % 8) * 8 +: 8] = c;
      applyStimulus(c, 1'b1, 5'(i / 8), word);
    end
    repeat (3) @(negedge clock);
    checkOutput("full_set",        {63'h0, full},       64'h1);
    checkOutput("full_char_ready", {63'h0, char_ready}, 64'h0);
    checkOutput("full_address",    {59'h0, address},    64'd31);
    // Input while full must be ignored (monitor flags any write)
    char_in    = 8'h5A;
    char_valid = 1'b1;
    repeat (4) @(negedge clock);
    char_valid = 1'b0;
    checkOutput("full_sticky",     {63'h0, full},       64'h1);
    checkOutput("full_ptr_held",   {59'h0, address},    64'd31);
    doReset();
    @(negedge clock);
    checkOutput("full_cleared",       {63'h0, full},       64'h0);
    checkOutput("ready_after_clear",  {63'h0, char_ready}, 64'h1);
    checkOutput("address_after_clear",{59'h0, address},    64'h0);

    // Reset asserted during the WRITE cycle of "A"
    applyStimulus(8'h41, 1'b1, 5'd0, 64'h41);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_in_write_write", {63'h0, write},      64'h0);
    checkOutput("rst_in_write_addr",  {59'h0, address},    64'h0);
    checkOutput("rst_in_write_ready", {63'h0, char_ready}, 64'h1);
    applyStimulus(8'h42, 1'b1, 5'd0, 64'h42);

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/character_buffer_packer.md
# character_buffer_packer

Packs the keyboard decoder's stream of 8-bit ASCII codes into 64-bit words, eight characters per word. Each word is written into the 32-entry character buffer register file through its `data_in`/`address`/`write` port. The block sits directly upstream of the buffer. It rewrites the word in progress on every accepted edit, so the display side always sees live text. It handles backspace and carriage return, and stops accepting input once all 32 words are filled.

## Interface
- `FLUSH_CHAR`, default 8'h0D: character that closes the current word early.
- `BACKSPACE_CHAR`, default 8'h08: character that deletes the last character of the current word.
- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `char_in`  input  8  ASCII code from the keyboard decoder.
- `char_valid`  input  1  `char_in` is valid.
- `char_ready`  output  1  packer can accept a character this cycle.
- `data_out`  output  64  word to write; drives the buffer's `data_in`.
- `address`  output  5  word pointer; drives the buffer's `address`.
- `write`  output  1  one-cycle write strobe to the buffer.
- `full`  output  1  sticky flag: all 32 words are committed.

## Operation
- State:
  - `shadow[63:0]`: word being built. Character k occupies bits [8k+7:8k]; character 0 is in the LSBs.
  - `idx[2:0]`: next free byte position in `shadow`.
  - `ptr[4:0]`: word pointer; drives `address`.
  - FSM states: IDLE, WRITE.
- Handshake:
  - A character is accepted on a rising edge where `char_valid & char_ready`.
  - `char_ready = (state==IDLE) & !full` (combinational).
- Accepted character, in IDLE:
  - Printable (8'h20–8'h7E): store it in byte `idx` of `shadow`. Set `wrap = (idx==7)`. Increment `idx`, wrapping 7 to 0. Go to WRITE.
  - `BACKSPACE_CHAR` with `idx>0`: decrement `idx`, clear that byte of `shadow`, go to WRITE.
  - `BACKSPACE_CHAR` with `idx==0`: no-op. Backspace never reaches into an already committed word.
  - `FLUSH_CHAR` with `idx>0`:
    - Clear `shadow`, set `idx=0`, increment `ptr`. The zero padding is already in the buffer from earlier writes.
    - No write; stay in IDLE.
    - If `ptr` was 31, set `full` instead of incrementing.
  - `FLUSH_CHAR` with `idx==0`: no-op.
  - Any other code: consumed and dropped; no state change.
- WRITE state (exactly one cycle):
  - `write=1`, `data_out=shadow`, `address=ptr`.
  - On the next edge, if `wrap` is set: clear `shadow`, then increment `ptr`, or set `full` if `ptr==31`. Clear `wrap`.
  - Return to IDLE.
- `full`:
  - Sticky until `reset`; `ptr` stays at 31 once full.
  - While full, `char_ready=0`, all input is ignored, and no writes occur.
- `data_out` always equals `shadow`. It is only meaningful while `write=1`.

## Timing
- Reset values:
  - `shadow=0`, `idx=0`, `ptr=0`, `wrap=0`, state IDLE.
  - Outputs: `write=0`, `full=0`, `address=0`, `data_out=0`, `char_ready=1`.
- Latency: a character accepted at edge T produces `write=1` during cycle T+1, with the updated word and the pre-increment `address`.
- Throughput: at most one character every 2 cycles, because `char_ready=0` throughout WRITE.
- `reset` asserted during WRITE: `write` drops on the same edge and the pending write is lost. All state returns to reset values.
- `reset` has priority over a simultaneous `char_valid`.
- Pointer advance on a full word is visible on `address` starting the cycle after the WRITE.

## Test plan
- Reset, then `char_in`=8'h41 with `char_valid`: next cycle `write=1`, `address=0`, `data_out=64'h0000_0000_0000_0041`; one cycle later `char_ready=1`.
- Feed "ABCDEFGH": final write has `address=0`, `data_out=64'h4847_4645_4443_4241`. Then "I" produces a write with `address=1`, `data_out=64'h49`.
- Feed "AB", then BS, then BS, then BS: the writes carry 64'h41, 64'h4241, 64'h41, 64'h0, all at `address=0`. The third BS produces no write.
- Feed "AB", then CR, then "C": CR causes no write and `address` becomes 1. "C" writes `data_out=64'h43` at `address=1`. A CR with `idx==0` leaves `address` unchanged.
- Feed 256 printable characters: the last write is at `address=31`, then `full=1` and `char_ready=0`. A further `char_valid` produces no write. Asserting `reset` clears `full`.
- Assert `reset` in the WRITE cycle of character "A": `write` is 0 in the following cycle, and `address=0`, `char_ready=1`.
